// File: rtl/top_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter with a runtime baud divisor latched per character.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module top_uart_tx #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 32,
  parameter int ADDR_WIDTH_FIFO = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk_i_top_tx,
  input  logic                    rst_i_top_tx,
  input  logic                    wr_i_top_tx,
  input  logic [DATA_WIDTH-1:0]   data_i_top_tx,
  input  logic [DATA_WIDTH*2:0]   baud_div_top_tx,
  output logic                    data_o_serial_top_tx,
  output logic                    busy_o_top_tx,
  output logic                    full_o_top_tx,
  output logic                    empty_o_top_tx,
  output logic                    overflow_o_top_tx
);

  localparam int BW = DATA_WIDTH*2+1;
  localparam int IW = $clog2(DATA_WIDTH+1);
  localparam logic [ADDR_WIDTH_FIFO:0]   DEPTH_C  = (ADDR_WIDTH_FIFO+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH_FIFO:0]   CNT_ONE  = (ADDR_WIDTH_FIFO+1)'(1);
  localparam logic [ADDR_WIDTH_FIFO-1:0] PTR_ONE  = ADDR_WIDTH_FIFO'(1);
  localparam logic [BW-1:0]              BAUD_ONE = BW'(1);
  localparam logic [IW-1:0]              IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]              IDX_LAST = IW'(DATA_WIDTH-1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH_FIFO-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH_FIFO:0]   count_q, count_d;
  logic                       full_q, empty_q, overflow_q;
  logic                       push, pop;

  // Transmit datapath
  state_t                     state_q;
  logic [DATA_WIDTH-1:0]      shift_q, shift_nxt, head;
  logic [BW-1:0]              bd_q, cnt_q, bd_in;
  logic [IW-1:0]              idx_q;
  logic                       line_q, busy_q, bit_end;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q;
`endif

  // Full is judged before any same-cycle pop, so a write at capacity is always dropped.
  assign push = wr_i_top_tx && !full_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_i_top_tx) begin
    if (push)
      mem_q[wr_ptr_q] <= data_i_top_tx;
  end

  always_ff @(posedge clk_i_top_tx or posedge rst_i_top_tx) begin
    if (rst_i_top_tx) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      if (wr_i_top_tx && full_q)
        overflow_q <= 1'b1;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign bd_in     = (baud_div_top_tx == '0) ? BAUD_ONE : baud_div_top_tx;
  assign bit_end   = (cnt_q == bd_q - BAUD_ONE);
  assign shift_nxt = shift_q >> 1;

  // A new character is taken from idle, or at the last stop-bit clock for gapless frames.
  assign pop = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_ff @(posedge clk_i_top_tx or posedge rst_i_top_tx) begin
    if (rst_i_top_tx) begin
      state_q  <= IDLE;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      shift_q  <= '0;
      bd_q     <= BAUD_ONE;
      cnt_q    <= '0;
      idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (pop) begin
      state_q  <= START;
      line_q   <= 1'b0;
      busy_q   <= 1'b1;
      shift_q  <= head;
      bd_q     <= bd_in;
      cnt_q    <= '0;
      idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= ^head;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          line_q <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= DATA;
            line_q  <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + BAUD_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              line_q  <= parity_q;
`else
              state_q <= STOP;
              line_q  <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + IDX_ONE;
              shift_q <= shift_nxt;
              line_q  <= shift_nxt[0];
            end
          end else begin
            cnt_q <= cnt_q + BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= STOP;
            line_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + BAUD_ONE;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            line_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + BAUD_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          line_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o_serial_top_tx = line_q;
  assign busy_o_top_tx        = busy_q;
  assign full_o_top_tx        = full_q;
  assign empty_o_top_tx       = empty_q;
  assign overflow_o_top_tx    = overflow_q;

endmodule

// File: tb/tb_top_uart_tx.sv
// Directed bench for top_uart_tx: checks every line clock of each frame against a hand-built bit pattern.
module tb_top_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [7:0]  data;
  logic [16:0] baud;
  logic        line, busy, full, empty, ovf;
  int          errors = 0;
  int          checks = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  top_uart_tx dut (
    .clk_i_top_tx         (clk),
    .rst_i_top_tx         (rst),
    .wr_i_top_tx          (wr),
    .data_i_top_tx        (data),
    .baud_div_top_tx      (baud),
    .data_o_serial_top_tx (line),
    .busy_o_top_tx        (busy),
    .full_o_top_tx        (full),
    .empty_o_top_tx       (empty),
    .overflow_o_top_tx    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at the negedge 'skip' clocks after the start bit began; leaves at the negedge after the frame.
  task automatic check_frame(input logic [7:0] b, input int bd, input int skip);
    logic [10:0] fr;
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = b;
`ifdef UART_TX_PARITY_EN
    fr[9]   = ^b;
`endif
    for (int k = skip; k < NB*bd; k++) begin
      chk($sformatf("line_%02h_k%0d", b, k), {31'd0, line}, {31'd0, fr[k/bd]});
      chk($sformatf("busy_%02h_k%0d", b, k), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; data = 8'h00; baud = 17'd4;
    repeat (2) @(negedge clk);
    chk("rst_line",  {31'd0, line},  32'd1);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 at 4 clocks per bit
    wr = 1'b1; data = 8'hA5;
    @(negedge clk);
    wr = 1'b0;
    chk("t1_empty_drop", {31'd0, empty}, 32'd0);
    chk("t1_line_idle",  {31'd0, line},  32'd1);
    chk("t1_busy_pre",   {31'd0, busy},  32'd0);
    @(negedge clk);
    chk("t1_empty_back", {31'd0, empty}, 32'd1);
    check_frame(8'hA5, 4, 0);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_line_end", {31'd0, line}, 32'd1);
    $display("txn single 0xA5 baud=4 done");

    // Burst of three bytes on consecutive cycles at 2 clocks per bit
    baud = 17'd2;
    wr = 1'b1; data = 8'h01;
    @(negedge clk);
    data = 8'h02;
    @(negedge clk);
    data = 8'h03;
    chk("t2_empty", {31'd0, empty}, 32'd0);
    @(negedge clk);
    wr = 1'b0;
    check_frame(8'h01, 2, 1);
    check_frame(8'h02, 2, 0);
    check_frame(8'h03, 2, 0);
    chk("t2_busy_end",  {31'd0, busy},  32'd0);
    chk("t2_empty_end", {31'd0, empty}, 32'd1);
    $display("txn burst 01/02/03 baud=2 done");

    // Divisor 0 behaves as 1
    baud = 17'd0;
    wr = 1'b1; data = 8'hFF;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    check_frame(8'hFF, 1, 0);
    chk("t3_busy_end", {31'd0, busy}, 32'd0);
    $display("txn 0xFF baud=0 done");

    // Divisor changed mid-frame only affects the next frame
    baud = 17'd3;
    wr = 1'b1; data = 8'h3C;
    @(negedge clk);
    data = 8'hC3;
    @(negedge clk);
    wr = 1'b0; baud = 17'd5;
    check_frame(8'h3C, 3, 0);
    check_frame(8'hC3, 5, 0);
    chk("t4_busy_end", {31'd0, busy}, 32'd0);
    $display("txn 3C@3 then C3@5 done");

    // Overflow: one byte on the line, then 33 writes into a 32-deep FIFO
    baud = 17'd100;
    wr = 1'b1; data = 8'h10;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 33; i++) begin
      wr = 1'b1; data = 8'(8'h20 + i);
      @(negedge clk);
      if (i == 30) chk("t5_not_full", {31'd0, full}, 32'd0);
      if (i == 31) begin
        chk("t5_full",       {31'd0, full}, 32'd1);
        chk("t5_ovf_before", {31'd0, ovf},  32'd0);
      end
    end
    wr = 1'b0; baud = 17'd1;
    chk("t5_ovf_set",  {31'd0, ovf},  32'd1);
    chk("t5_full_hold", {31'd0, full}, 32'd1);
    check_frame(8'h10, 100, 33);
    for (int i = 0; i < 32; i++)
      check_frame(8'(8'h20 + i), 1, 0);
    chk("t5_busy_end",  {31'd0, busy},  32'd0);
    chk("t5_empty_end", {31'd0, empty}, 32'd1);
    chk("t5_ovf_stick", {31'd0, ovf},   32'd1);
    $display("txn overflow burst of 33 done");

    // Reset during data bit 3 of 0x55 with another byte queued
    baud = 17'd4;
    wr = 1'b1; data = 8'h55;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    wr = 1'b1; data = 8'h66;
    @(negedge clk);
    wr = 1'b0;
    repeat (16) @(negedge clk);
    chk("t6_bit3", {31'd0, line}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_line",  {31'd0, line},  32'd1);
    chk("t6_rst_busy",  {31'd0, busy},  32'd0);
    chk("t6_rst_empty", {31'd0, empty}, 32'd1);
    chk("t6_rst_ovf",   {31'd0, ovf},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("t6_quiet_line_%0d", i), {31'd0, line}, 32'd1);
      chk($sformatf("t6_quiet_busy_%0d", i), {31'd0, busy}, 32'd0);
    end
    $display("txn reset mid-frame done");

`ifdef UART_TX_PARITY_EN
    baud = 17'd2;
    wr = 1'b1; data = 8'h07;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    check_frame(8'h07, 2, 0);
    chk("t7_busy_end", {31'd0, busy}, 32'd0);
    $display("txn parity 0x07 done");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
